reg_file: RTL and testbench



---
 rtl/riscv_pkg.sv | 14 +
 rtl/reg_file_read_port.sv | 65 ++++++
 rtl/reg_file.sv | 83 ++++++++
 tb/tb_reg_file.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V integer core datapath.
//   XLEN        default integer data width
//   NREGS_DEF   default architectural register count
//   reg_addr_t  register index type for the default register count
//   REG_ZERO    index of the hard-wired zero register
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port of the integer register file.
// Selects the addressed entry, masks the zero register, optionally forwards
// a same-edge write and registers data plus busy flag.
//   clk, reset   clock, asynchronous active-high reset
//   rd_en        port enable; when low the outputs are cleared at the edge
//   rd_addr      register index to read
//   regs_flat    flattened register array, entry i at [i*XLEN +: XLEN]
//   busy_vec     current busy bits
//   wr_en/addr/data  write port of the same edge, used for forwarding
//   rd_data      registered read data
//   rd_busy      registered busy flag of the addressed register
module reg_file_read_port #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  input  logic [NREGS*XLEN-1:0] regs_flat,
  input  logic [NREGS-1:0]      busy_vec,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic [XLEN-1:0]       rd_data,
  output logic                  rd_busy
);
  import riscv_pkg::*;

  logic [XLEN-1:0] w_stored;
  logic            w_stored_busy;
  logic            w_is_zero;
  logic            w_fwd;
  logic [XLEN-1:0] r_rd_data;
  logic            r_rd_busy;

  assign w_stored      = regs_flat[rd_addr*XLEN +: XLEN];
  assign w_stored_busy = busy_vec[rd_addr];
  assign w_is_zero     = (ZERO_REG != 0) && (rd_addr == AW'(REG_ZERO));
  // Forward only the write; a same-edge reserve is deliberately not forwarded.
  assign w_fwd         = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
      r_rd_busy <= 1'b0;
    end else if (!rd_en || w_is_zero) begin
      r_rd_data <= '0;
      r_rd_busy <= 1'b0;
    end else if (w_fwd) begin
      r_rd_data <= wr_data;
      r_rd_busy <= 1'b0;
    end else begin
      r_rd_data <= w_stored;
      r_rd_busy <= w_stored_busy;
    end
  end

  assign rd_data = r_rd_data;
  assign rd_busy = r_rd_busy;

endmodule

// File: rtl/reg_file.sv
// Multi-port integer register file with per-register busy (scoreboard) bits.
//   clk, reset   clock, asynchronous active-high reset
//   rd_en        per-port read enable (NREAD)
//   rd_addr      packed read addresses, port p at [p*AW +: AW]
//   rd_data      packed registered read data, port p at [p*XLEN +: XLEN]
//   rd_busy      registered busy flag per port
//   wr_en/addr/data  write port; a write clears the busy bit
//   resv_en/addr     reserve port; sets the busy bit, wins over a write
//   busy_vec     live busy bits
module reg_file #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NREGS    = riscv_pkg::NREGS_DEF,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  resv_en,
  input  logic [AW-1:0]         resv_addr,
  output logic [NREGS-1:0]      busy_vec
);
  import riscv_pkg::*;

  logic [NREGS-1:0][XLEN-1:0] r_regs;
  logic [NREGS-1:0]           r_busy;
  logic [NREGS*XLEN-1:0]      w_regs_flat;
  logic                       w_wr_ok;
  logic                       w_resv_ok;

  assign w_wr_ok   = wr_en   && !((ZERO_REG != 0) && (wr_addr   == AW'(REG_ZERO)));
  assign w_resv_ok = resv_en && !((ZERO_REG != 0) && (resv_addr == AW'(REG_ZERO)));

  // Reserve is applied after the write so that it wins on the same address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[wr_addr] <= wr_data;
        r_busy[wr_addr] <= 1'b0;
      end
      if (w_resv_ok) begin
        r_busy[resv_addr] <= 1'b1;
      end
    end
  end

  assign w_regs_flat = r_regs;
  assign busy_vec    = r_busy;

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    reg_file_read_port #(
      .XLEN    (XLEN),
      .NREGS   (NREGS),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG),
      .AW      (AW)
    ) u_rd_port (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en[p]),
      .rd_addr  (rd_addr[p*AW +: AW]),
      .regs_flat(w_regs_flat),
      .busy_vec (r_busy),
      .wr_en    (w_wr_ok),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[p*XLEN +: XLEN]),
      .rd_busy  (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk;
  logic                  reset;
  logic [NREAD-1:0]      rd_en;
  logic [NREAD*AW-1:0]   rd_addr;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  resv_en;
  logic [AW-1:0]         resv_addr;

  logic [NREAD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NREAD-1:0]      rd_busy_b, rd_busy_n;
  logic [NREGS-1:0]      busy_vec_b, busy_vec_n;

  int checks = 0;
  int errors = 0;

  reg_file #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .resv_en(resv_en), .resv_addr(resv_addr), .busy_vec(busy_vec_b)
  );

  reg_file #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0), .ZERO_REG(1)) u_dut_n (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .resv_en(resv_en), .resv_addr(resv_addr), .busy_vec(busy_vec_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; wr_en = 1'b0; resv_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rd_en = '0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    resv_en = 1'b0; resv_addr = '0;

    // 1. reset
    step(); step();
    check("rst_rd_data", {32'd0, rd_data_b}, 64'd0);
    check("rst_busy_vec", {32'd0, busy_vec_b}, 64'd0);
    reset = 1'b0;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    step();
    check("rst_read_x5", {32'd0, rd_data_b[31:0]}, 64'd0);
    check("rst_read_x5_busy", {63'd0, rd_busy_b[0]}, 64'd0);

    // 2. write then read on both ports
    idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    idle(); rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    step();
    check("wr_rd_p0", {32'd0, rd_data_b[31:0]}, 64'hDEADBEEF);
    check("wr_rd_p1", {32'd0, rd_data_b[63:32]}, 64'hDEADBEEF);
    check("wr_rd_n_p1", {32'd0, rd_data_n[63:32]}, 64'hDEADBEEF);
    // disabled port drives zero
    rd_en = 2'b01;
    step();
    check("dis_p1_data", {32'd0, rd_data_b[63:32]}, 64'd0);
    check("en_p0_data", {32'd0, rd_data_b[31:0]}, 64'hDEADBEEF);

    // 3. zero register
    idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    resv_en = 1'b1; resv_addr = 5'd0;
    step();
    check("x0_busy_vec", {63'd0, busy_vec_b[0]}, 64'd0);
    idle(); rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    step();
    check("x0_rd_data", {rd_data_b[63:32], rd_data_b[31:0]}, 64'd0);
    check("x0_rd_busy", {62'd0, rd_busy_b}, 64'd0);

    // 4. bypass
    idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
    step();
    idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    step();
    check("byp1_data", {32'd0, rd_data_b[31:0]}, 64'h22);
    check("byp1_busy", {63'd0, rd_busy_b[0]}, 64'd0);
    check("byp0_data", {32'd0, rd_data_n[31:0]}, 64'h11);
    idle(); rd_en = 2'b01;
    step();
    check("byp0_after", {32'd0, rd_data_n[31:0]}, 64'h22);

    // 5. scoreboard
    idle(); resv_en = 1'b1; resv_addr = 5'd3;
    step();
    check("resv_x3_vec", {63'd0, busy_vec_b[3]}, 64'd1);
    idle(); rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
    step();
    check("resv_x3_rd_busy", {63'd0, rd_busy_b[1]}, 64'd1);
    check("resv_x3_rd_busy_n", {63'd0, rd_busy_n[1]}, 64'd1);
    // reserve is not forwarded to a same-edge read
    idle(); resv_en = 1'b1; resv_addr = 5'd4; rd_en = 2'b01; rd_addr = {5'd0, 5'd4};
    step();
    check("resv_nofwd_busy", {63'd0, rd_busy_b[0]}, 64'd0);
    check("resv_x4_vec", {63'd0, busy_vec_b[4]}, 64'd1);
    idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h40;
    step();
    check("wr_clr_x3", {63'd0, busy_vec_b[3]}, 64'd0);
    idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h99;
    resv_en = 1'b1; resv_addr = 5'd3;
    step();
    check("resv_wins_x3", {63'd0, busy_vec_b[3]}, 64'd1);
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    step();
    check("resv_wr_data", {32'd0, rd_data_b[31:0]}, 64'h99);
    check("resv_wr_busy", {63'd0, rd_busy_b[0]}, 64'd1);

    // 6. asynchronous reset mid-operation
    idle(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
    step();
    idle(); resv_en = 1'b1; resv_addr = 5'd9;
    step();
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    step();
    check("pre_rst_data", {32'd0, rd_data_b[31:0]}, 64'hAA);
    check("pre_rst_busy", {63'd0, busy_vec_b[9]}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_busy_vec", {32'd0, busy_vec_b}, 64'd0);
    check("async_rd_data", rd_data_b, 64'd0);
    check("async_rd_busy", {62'd0, rd_busy_b}, 64'd0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_x9", {32'd0, rd_data_b[31:0]}, 64'd0);
    check("post_rst_x9_n", {32'd0, rd_data_n[31:0]}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
